// File: rtl/commit_trace_fifo.sv
// Commit-trace FIFO: captures W-stage GRF write-backs and M-stage stores in program order
// and presents them first-word-fall-through over a valid/ready read port.
module commit_trace_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DROP_W     = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  grf_we,
    input  logic [31:0]           grf_pc,
    input  logic [4:0]            grf_addr,
    input  logic [31:0]           grf_wdata,
    input  logic                  dm_we,
    input  logic [31:0]           dm_pc,
    input  logic [31:0]           dm_addr,
    input  logic [31:0]           dm_wdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_kind,
    output logic [31:0]           out_pc,
    output logic [31:0]           out_addr,
    output logic [31:0]           out_data,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic [DROP_W-1:0]     drop_cnt
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef logic [DEPTH_LOG2-1:0] ptr_t;
    typedef logic [DEPTH_LOG2:0]   cnt_t;
    typedef logic [DROP_W:0]       dsum_t;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } entry_t;

    entry_t            mem_q [DEPTH];
    ptr_t              wptr_q, wptr_d;
    ptr_t              rptr_q, rptr_d;
    ptr_t              wptr_p1;
    cnt_t              count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic   grf_ev, dm_ev;
    logic   grf_ok, dm_ok;
    logic   pop;
    cnt_t   space;
    logic   [1:0] n_push, n_drop;
    dsum_t  drop_sum;
    entry_t grf_ent, dm_ent, head;
    logic   we0, we1;
    entry_t wd0, wd1;

    always_comb begin
        grf_ev  = grf_we && (grf_addr != 5'd0);
        dm_ev   = dm_we;
        // Space comes from the registered count only; a same-cycle pop never makes room.
        space   = cnt_t'(DEPTH) - count_q;
        grf_ok  = grf_ev && (space != '0);
        dm_ok   = dm_ev && (space >= (grf_ev ? cnt_t'(2) : cnt_t'(1)));

        grf_ent = '{kind: 1'b0, pc: grf_pc, addr: {27'd0, grf_addr}, data: grf_wdata};
        dm_ent  = '{kind: 1'b1, pc: dm_pc, addr: dm_addr, data: dm_wdata};

        // The older GRF event takes the first slot; the store follows it.
        we0     = grf_ok || dm_ok;
        wd0     = grf_ok ? grf_ent : dm_ent;
        we1     = grf_ok && dm_ok;
        wd1     = dm_ent;
        wptr_p1 = wptr_q + ptr_t'(1);

        n_push  = {1'b0, grf_ok} + {1'b0, dm_ok};
        n_drop  = {1'b0, grf_ev && !grf_ok} + {1'b0, dm_ev && !dm_ok};

        pop     = (count_q != '0) && out_ready;
        count_d = count_q + cnt_t'(n_push) - cnt_t'(pop);
        wptr_d  = wptr_q + ptr_t'(n_push);
        rptr_d  = rptr_q + ptr_t'(pop);

        drop_sum   = {1'b0, drop_q} + dsum_t'(n_drop);
        drop_d     = drop_sum[DROP_W] ? '1 : drop_sum[DROP_W-1:0];
        overflow_d = overflow_q || (n_drop != 2'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem_q[wptr_q] <= wd0;
        if (we1) mem_q[wptr_p1] <= wd1;
    end

    // Head fields are forced to zero while empty so stale slots never leak out.
    always_comb begin
        head      = mem_q[rptr_q];
        out_valid = (count_q != '0);
        out_kind  = out_valid ? head.kind : 1'b0;
        out_pc    = out_valid ? head.pc   : 32'd0;
        out_addr  = out_valid ? head.addr : 32'd0;
        out_data  = out_valid ? head.data : 32'd0;
        count     = count_q;
        overflow  = overflow_q;
        drop_cnt  = drop_q;
    end

endmodule
